// File: rtl/matrix_pkg.sv
// Shared constants and FSM state encoding for the matrix operation sequencer.
package matrix_pkg;

  localparam int MAT_W   = 256;
  localparam int ELEM_W  = 16;
  localparam int MAT_DIM = 4;

  typedef enum logic [3:0] {
    IDLE,
    RDA,
    LDA,
    RDB,
    LDB,
    RES,
    CAP,
    WB,
    DONE
  } opState_t;

endpackage

// File: rtl/matrix_op_sequencer.sv
// Sequences one C = A x B operation: read A and B from matrix memory, load the
// external multiplier, capture its result and write it back. OP_COUNT_EN adds op_count.
import matrix_pkg::*;

module matrix_op_sequencer #(
  parameter int ADDR_W = 4,
  parameter int ELEM_W = 16
) (
  input  logic                                clk,
  input  logic                                nreset,
  input  logic                                start,
  input  logic [ADDR_W-1:0]                   src_a_addr,
  input  logic [ADDR_W-1:0]                   src_b_addr,
  input  logic [ADDR_W-1:0]                   dst_addr,
  output logic                                busy,
  output logic                                done,
  output logic [ADDR_W-1:0]                   mem_addr,
  output logic                                mem_rd_en,
  output logic                                mem_wr_en,
  output logic [ELEM_W*MAT_DIM*MAT_DIM-1:0]   mem_wdata,
  input  logic [ELEM_W*MAT_DIM*MAT_DIM-1:0]   mem_rdata,
  output logic [ELEM_W*MAT_DIM*MAT_DIM-1:0]   mult_data,
  output logic                                mult_enable,
  output logic                                mult_rw,
  input  logic [ELEM_W*MAT_DIM*MAT_DIM-1:0]   mult_result
`ifdef OP_COUNT_EN
  ,
  output logic [15:0]                         op_count
`endif
);

  localparam int WordW = ELEM_W * MAT_DIM * MAT_DIM;

  opState_t          state;
  opState_t          nextState;
  logic [ADDR_W-1:0] srcAReg;
  logic [ADDR_W-1:0] srcBReg;
  logic [ADDR_W-1:0] dstReg;
  logic [WordW-1:0]  resultReg;

  // Addresses are latched at start so the caller may change them mid-operation.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state     <= IDLE;
      srcAReg   <= '0;
      srcBReg   <= '0;
      dstReg    <= '0;
      resultReg <= '0;
    end else begin
      state <= nextState;
      if (state == IDLE && start) begin
        srcAReg <= src_a_addr;
        srcBReg <= src_b_addr;
        dstReg  <= dst_addr;
      end
      if (state == CAP) begin
        resultReg <= mult_result;
      end
    end
  end

  always_comb begin
    nextState   = state;
    busy        = (state != IDLE);
    done        = 1'b0;
    mem_addr    = '0;
    mem_rd_en   = 1'b0;
    mem_wr_en   = 1'b0;
    mem_wdata   = resultReg;
    mult_data   = '0;
    mult_enable = 1'b0;
    mult_rw     = 1'b0;
    case (state)
      IDLE: begin
        if (start) nextState = RDA;
      end
      RDA: begin
        mem_rd_en = 1'b1;
        mem_addr  = srcAReg;
        nextState = LDA;
      end
      LDA: begin
        mult_data   = mem_rdata;
        mult_enable = 1'b1;
        mult_rw     = 1'b1;
        nextState   = RDB;
      end
      RDB: begin
        mem_rd_en = 1'b1;
        mem_addr  = srcBReg;
        nextState = LDB;
      end
      LDB: begin
        mult_data   = mem_rdata;
        mult_enable = 1'b1;
        mult_rw     = 1'b1;
        nextState   = RES;
      end
      RES: begin
        mult_enable = 1'b1;
        nextState   = CAP;
      end
      CAP: begin
        nextState = WB;
      end
      WB: begin
        mem_wr_en = 1'b1;
        mem_addr  = dstReg;
        nextState = DONE;
      end
      DONE: begin
        done      = 1'b1;
        nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

`ifdef OP_COUNT_EN
  logic [15:0] opCount;

  // Free-running count of completed operations; wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      opCount <= '0;
    end else if (state == DONE) begin
      opCount <= opCount + 16'd1;
    end
  end

  assign op_count = opCount;
`endif

endmodule

// File: tb/tb_matrix_op_sequencer.sv
// Directed bench for matrix_op_sequencer with a behavioural memory and 4x4 multiplier.
// Define OP_COUNT_EN to also exercise the operation counter.
module tb_matrix_op_sequencer;

  localparam int ADDR_W = 4;
  localparam int W      = 256;

  logic              clk = 1'b0;
  logic              nreset;
  logic              start;
  logic [ADDR_W-1:0] srcA, srcB, dst;
  logic              busy, done;
  logic [ADDR_W-1:0] memAddr;
  logic              memRdEn, memWrEn;
  logic [W-1:0]      memWdata, memRdata, multData, multResult;
  logic              multEnable, multRw;
`ifdef OP_COUNT_EN
  logic [15:0]       opCount;
`endif

  logic [W-1:0]      mem [16];
  logic              tbLoad;
  logic [ADDR_W-1:0] tbAddr;
  logic [W-1:0]      tbData;
  logic [W-1:0]      matA, matB;
  logic              loadSel;
  int                writeCount, doneCount;
  int                checks, failures;

  localparam logic [W-1:0] IDENT = {16'h0001, {4{16'h0000}}, 16'h0001, {4{16'h0000}},
                                    16'h0001, {4{16'h0000}}, 16'h0001};
  localparam logic [W-1:0] ALL1  = {16{16'h0001}};
  localparam logic [W-1:0] ALL2  = {16{16'h0002}};
  localparam logic [W-1:0] ALL4  = {16{16'h0004}};
  localparam logic [W-1:0] DIAG  = {16'h0004, {4{16'h0000}}, 16'h0003, {4{16'h0000}},
                                    16'h0002, {4{16'h0000}}, 16'h0001};
  localparam logic [W-1:0] DIAG2 = {16'h0010, {4{16'h0000}}, 16'h0009, {4{16'h0000}},
                                    16'h0004, {4{16'h0000}}, 16'h0001};
  localparam logic [W-1:0] MARK  = {16{16'hBEEF}};

  matrix_op_sequencer #(.ADDR_W(ADDR_W), .ELEM_W(16)) dut (
    .clk         (clk),
    .nreset      (nreset),
    .start       (start),
    .src_a_addr  (srcA),
    .src_b_addr  (srcB),
    .dst_addr    (dst),
    .busy        (busy),
    .done        (done),
    .mem_addr    (memAddr),
    .mem_rd_en   (memRdEn),
    .mem_wr_en   (memWrEn),
    .mem_wdata   (memWdata),
    .mem_rdata   (memRdata),
    .mult_data   (multData),
    .mult_enable (multEnable),
    .mult_rw     (multRw),
    .mult_result (multResult)
`ifdef OP_COUNT_EN
    ,
    .op_count    (opCount)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] matMul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] c;
    logic [15:0]  acc;
    c = '0;
    for (int r = 0; r < 4; r++) begin
      for (int col = 0; col < 4; col++) begin
        acc = 16'h0000;
        for (int k = 0; k < 4; k++) begin
          acc = acc + a[(r*4+k)*16 +: 16] * b[(k*4+col)*16 +: 16];
        end
        c[(r*4+col)*16 +: 16] = acc;
      end
    end
    return c;
  endfunction

  // Synchronous memory with one-cycle read latency, plus a bench backdoor loader.
  always @(posedge clk) begin
    if (memRdEn) memRdata <= mem[memAddr];
    if (memWrEn) mem[memAddr] = memWdata;
    if (tbLoad) mem[tbAddr] = tbData;
  end

  // Multiplier model: first load is A, second is B, a read-mode enable computes A x B.
  always @(posedge clk) begin
    if (!nreset) begin
      loadSel <= 1'b0;
    end else if (multEnable && multRw) begin
      if (!loadSel) matA <= multData;
      else          matB <= multData;
      loadSel <= ~loadSel;
    end else if (multEnable && !multRw) begin
      multResult <= matMul(matA, matB);
      loadSel    <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (memWrEn) writeCount <= writeCount + 1;
    if (done)    doneCount  <= doneCount + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b,
                               input logic [ADDR_W-1:0] d);
    srcA  = a;
    srcB  = b;
    dst   = d;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [W-1:0] d);
    tbAddr = a;
    tbData = d;
    tbLoad = 1'b1;
    tick();
    tbLoad = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"},   W'(busy), '0);
    checkOutput({tag, "_done"},   W'(done), '0);
    checkOutput({tag, "_addr"},   W'(memAddr), '0);
    checkOutput({tag, "_strobe"}, W'({memRdEn, memWrEn, multEnable, multRw}), '0);
    checkOutput({tag, "_wdata"},  memWdata, '0);
    checkOutput({tag, "_mdata"},  multData, '0);
  endtask

  int wrBase, dnBase;

  initial begin
    checks = 0; failures = 0; writeCount = 0; doneCount = 0;
    nreset = 1'b0; start = 1'b0; srcA = '0; srcB = '0; dst = '0;
    tbLoad = 1'b0; tbAddr = '0; tbData = '0;
    for (int i = 0; i < 16; i++) preload(ADDR_W'(i), '0);
    preload(4'd0, IDENT);
    preload(4'd1, ALL2);
    preload(4'd4, ALL1);
    preload(4'd5, ALL1);
    preload(4'd7, MARK);
    preload(4'd3, DIAG);
    checkAllZero("reset");
    nreset = 1'b1;
    tick();

    $display("[TB] identity x all-2 with per-cycle checks");
    wrBase = writeCount; dnBase = doneCount;
    applyStimulus(4'd0, 4'd1, 4'd2);
    checkOutput("t1_busy", W'(busy), W'(1));
    checkOutput("t1_rda", W'({memRdEn, memWrEn, memAddr}), W'({2'b10, 4'd0}));
    tick();
    checkOutput("t2_lda_ctl", W'({multEnable, multRw, busy}), W'(3'b111));
    checkOutput("t2_lda_data", multData, IDENT);
    tick();
    checkOutput("t3_rdb", W'({memRdEn, memWrEn, memAddr}), W'({2'b10, 4'd1}));
    tick();
    checkOutput("t4_ldb_data", multData, ALL2);
    tick();
    checkOutput("t5_res", W'({multEnable, multRw, memRdEn, memWrEn}), W'(4'b1000));
    tick();
    checkOutput("t6_cap", W'({multEnable, memRdEn, memWrEn, busy, done}), W'(5'b00010));
    tick();
    checkOutput("t7_wb", W'({memRdEn, memWrEn, memAddr}), W'({2'b01, 4'd2}));
    checkOutput("t7_wdata", memWdata, ALL2);
    tick();
    checkOutput("t8_done", W'({done, busy, memWrEn}), W'(3'b110));
    tick();
    checkOutput("t9_idle", W'({done, busy}), W'(2'b00));
    checkOutput("t9_hold_wdata", memWdata, ALL2);
    checkOutput("op1_mem2", mem[2], ALL2);
    checkOutput("op1_counts", W'({8'(writeCount - wrBase), 8'(doneCount - dnBase)}), W'(16'h0101));

    $display("[TB] all-1 x all-1 with extra start during busy");
    wrBase = writeCount; dnBase = doneCount;
    applyStimulus(4'd4, 4'd5, 4'd6);
    tick(); tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick(); tick();
    checkOutput("op2_done", W'(done), W'(1));
    tick();
    tick();
    checkOutput("op2_not_restarted", W'(busy), '0);
    checkOutput("op2_mem6", mem[6], ALL4);
    checkOutput("op2_counts", W'({8'(writeCount - wrBase), 8'(doneCount - dnBase)}), W'(16'h0101));

    $display("[TB] reset asserted during LDB");
    wrBase = writeCount; dnBase = doneCount;
    applyStimulus(4'd0, 4'd1, 4'd7);
    tick(); tick(); tick();
    checkOutput("rst_in_ldb", W'({multEnable, multRw, busy}), W'(3'b111));
    nreset = 1'b0;
    tick();
    nreset = 1'b1;
    checkAllZero("rst_abort");
    for (int i = 0; i < 10; i++) tick();
    checkOutput("rst_no_wr_done", W'({8'(writeCount - wrBase), 8'(doneCount - dnBase)}), '0);
    checkOutput("rst_mem7", mem[7], MARK);

    $display("[TB] aliased src_a=src_b=dst=3");
    wrBase = writeCount;
    applyStimulus(4'd3, 4'd3, 4'd3);
    checkOutput("alias_rda", W'({memRdEn, memAddr}), W'({1'b1, 4'd3}));
    tick();
    checkOutput("alias_lda", multData, DIAG);
    tick();
    checkOutput("alias_rdb", W'({memRdEn, memWrEn, memAddr}), W'({2'b10, 4'd3}));
    tick();
    checkOutput("alias_ldb", multData, DIAG);
    tick(); tick(); tick();
    checkOutput("alias_wb", W'({memRdEn, memWrEn, memAddr}), W'({2'b01, 4'd3}));
    checkOutput("alias_wdata", memWdata, DIAG2);
    tick(); tick();
    checkOutput("alias_mem3", mem[3], DIAG2);
    checkOutput("alias_one_write", W'(writeCount - wrBase), W'(1));

`ifdef OP_COUNT_EN
    $display("[TB] op_count wrap");
    force dut.opCount = 16'hFFFF;
    tick();
    release dut.opCount;
    checkOutput("cnt_preset", W'(opCount), W'(16'hFFFF));
    applyStimulus(4'd4, 4'd5, 4'd8);
    for (int i = 0; i < 8; i++) tick();
    checkOutput("cnt_wrap", W'(opCount), W'(16'h0000));
    applyStimulus(4'd4, 4'd5, 4'd9);
    for (int i = 0; i < 8; i++) tick();
    checkOutput("cnt_after_wrap", W'(opCount), W'(16'h0001));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
